// File: rtl/sdram_button_master.sv
// Push-button front end for the SDRAM Avalon-MM slave: debounced presses start single-beat
// writes/reads or step the word address; read data goes to the LEDs; stuck transfers time out.
module sdram_button_master #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 1023,
    parameter int ADDR_W          = 25
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic [15:0]       sw_data,
    input  logic              button_write,
    input  logic              button_read,
    input  logic              button_addr,
    output logic [ADDR_W-1:0] av_address,
    output logic [3:0]        av_byteenable_n,
    output logic              av_chipselect,
    output logic [31:0]       av_writedata,
    output logic              av_write_n,
    output logic              av_read_n,
    input  logic [31:0]       av_readdata,
    input  logic              av_readdatavalid,
    input  logic              av_waitrequest,
    output logic [15:0]       led,
    output logic [7:0]        led_addr,
    output logic              busy,
    output logic              error
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

    // Bit order: 0 = write, 1 = read, 2 = address.
    logic [2:0] btn_raw;
    logic [2:0] press;
    assign btn_raw = {button_addr, button_read, button_write};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_btn
            logic [1:0]      sync_q, sync_d;
            logic            level_q, level_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            // The counter only runs while the synchronised level disagrees with the accepted one,
            // so any bounce back to the accepted level restarts the stability window.
            always_comb begin
                sync_d  = {sync_q[0], btn_raw[gi]};
                level_d = level_q;
                cnt_d   = cnt_q;
                if (sync_q[1] == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    level_d = sync_q[1];
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            assign press[gi] = level_q & ~sync_q[1] & (cnt_q == DB_LAST);

            always_ff @(posedge clk_50mhz or negedge reset) begin
                if (!reset) begin
                    sync_q  <= 2'b11;
                    level_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sync_q  <= sync_d;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                end
            end
        end
    endgenerate

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              cs_q, cs_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_n_q, write_n_d;
    logic              read_n_q, read_n_d;
    logic [15:0]       led_q, led_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_n_d    = be_n_q;
        cs_d      = cs_q;
        wdata_d   = wdata_q;
        write_n_d = write_n_q;
        read_n_d  = read_n_q;
        led_d     = led_q;
        error_d   = error_q;
        tmo_d     = tmo_q;

        case (state_q)
            IDLE: begin
                if (press[2]) addr_d = addr_q + ADDR_W'(1);
                if (press[0]) begin
                    state_d   = WR_REQ;
                    wdata_d   = {16'h0000, sw_data};
                    write_n_d = 1'b0;
                    cs_d      = 1'b1;
                    be_n_d    = 4'h0;
                    error_d   = 1'b0;
                    tmo_d     = '0;
                end else if (press[1]) begin
                    state_d  = RD_REQ;
                    read_n_d = 1'b0;
                    cs_d     = 1'b1;
                    be_n_d   = 4'h0;
                    error_d  = 1'b0;
                    tmo_d    = '0;
                end
            end
            WR_REQ: begin
                if (!av_waitrequest) begin
                    write_n_d = 1'b1;
                    cs_d      = 1'b0;
                    be_n_d    = 4'hF;
                    state_d   = IDLE;
                end
            end
            RD_REQ: begin
                if (!av_waitrequest) begin
                    read_n_d = 1'b1;
                    cs_d     = 1'b0;
                    be_n_d   = 4'hF;
                    if (av_readdatavalid) begin
                        led_d   = av_readdata[15:0];
                        state_d = IDLE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (av_readdatavalid) begin
                    led_d   = av_readdata[15:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer that completes on its last allowed cycle still counts as completed.
        if (state_q != IDLE) begin
            if (state_d != IDLE && tmo_q == TO_LAST) begin
                state_d   = IDLE;
                write_n_d = 1'b1;
                read_n_d  = 1'b1;
                cs_d      = 1'b0;
                be_n_d    = 4'hF;
                error_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_n_q    <= 4'hF;
            cs_q      <= 1'b0;
            wdata_q   <= '0;
            write_n_q <= 1'b1;
            read_n_q  <= 1'b1;
            led_q     <= '0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_n_q    <= be_n_d;
            cs_q      <= cs_d;
            wdata_q   <= wdata_d;
            write_n_q <= write_n_d;
            read_n_q  <= read_n_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            tmo_q     <= tmo_d;
        end
    end

    logic unused_rdata_hi;
    assign unused_rdata_hi = ^av_readdata[31:16];

    assign av_address      = addr_q;
    assign av_byteenable_n = be_n_q;
    assign av_chipselect   = cs_q;
    assign av_writedata    = wdata_q;
    assign av_write_n      = write_n_q;
    assign av_read_n       = read_n_q;
    assign led             = led_q;
    assign led_addr        = 8'(addr_q);
    assign busy            = busy_q;
    assign error           = error_q;
endmodule

// File: tb/tb_sdram_button_master.sv
// Directed bench for sdram_button_master (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16); a second,
// 8-bit-address instance shares the inputs so the address wrap is reachable by presses.
module tb_sdram_button_master;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset;
    logic [15:0] sw_data;
    logic        bw, br, ba;
    logic [31:0] rdata;
    logic        rvalid, wait_req;

    logic [24:0] av_address;
    logic [3:0]  be_n;
    logic        cs;
    logic [31:0] wdata;
    logic        write_n, read_n;
    logic [15:0] led;
    logic [7:0]  led_addr;
    logic        busy, error;

    logic [7:0]  addr2, led_addr2;
    logic [3:0]  unused_be_n2;
    logic        unused_cs2, unused_write_n2, unused_read_n2, unused_busy2, unused_error2;
    logic [31:0] unused_wdata2;
    logic [15:0] unused_led2;

    int checks = 0;
    int passes = 0;
    logic [24:0] exp_addr;
    logic [89:0] snap;
    localparam logic [89:0] SNAP_RESET =
        {25'd0, 4'hF, 1'b0, 32'd0, 1'b1, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0};

    assign snap = {av_address, be_n, cs, wdata, write_n, read_n, led, led_addr, busy, error};

    sdram_button_master #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16), .ADDR_W(25)) dut (
        .clk_50mhz(clk), .reset(reset), .sw_data(sw_data),
        .button_write(bw), .button_read(br), .button_addr(ba),
        .av_address(av_address), .av_byteenable_n(be_n), .av_chipselect(cs),
        .av_writedata(wdata), .av_write_n(write_n), .av_read_n(read_n),
        .av_readdata(rdata), .av_readdatavalid(rvalid), .av_waitrequest(wait_req),
        .led(led), .led_addr(led_addr), .busy(busy), .error(error)
    );

    sdram_button_master #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16), .ADDR_W(8)) dut2 (
        .clk_50mhz(clk), .reset(reset), .sw_data(sw_data),
        .button_write(bw), .button_read(br), .button_addr(ba),
        .av_address(addr2), .av_byteenable_n(unused_be_n2), .av_chipselect(unused_cs2),
        .av_writedata(unused_wdata2), .av_write_n(unused_write_n2), .av_read_n(unused_read_n2),
        .av_readdata(rdata), .av_readdatavalid(rvalid), .av_waitrequest(wait_req),
        .led(unused_led2), .led_addr(led_addr2), .busy(unused_busy2), .error(unused_error2)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; bw = 1'b1; br = 1'b1; ba = 1'b1;
        sw_data = 16'h0; rdata = 32'h0; rvalid = 1'b0; wait_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (snap !== SNAP_RESET) $display("FAIL reset_async: got %h expected %h", snap, SNAP_RESET);
        else passes++;
        step(3);
        reset = 1'b1;
        step(3);
        checks++;
        if (snap !== SNAP_RESET) $display("FAIL reset_idle: got %h expected %h", snap, SNAP_RESET);
        else passes++;
        $display("reset: outputs=%h", snap);
    endtask

    task automatic test_addr_wrap();
        for (int i = 1; i <= 256; i++) begin
            ba = 1'b0; step(8);
            ba = 1'b1; step(8);
            if (i == 1) begin
                checks++;
                if (av_address !== 25'd1 || addr2 !== 8'd1)
                    $display("FAIL addr_first: got %h/%h expected 1/1", av_address, addr2);
                else passes++;
            end
            if (i == 255) begin
                checks++;
                if (addr2 !== 8'hFF || led_addr !== 8'hFF)
                    $display("FAIL addr_max: got %h/%h expected ff/ff", addr2, led_addr);
                else passes++;
            end
        end
        checks++;
        if (addr2 !== 8'h00 || led_addr2 !== 8'h00)
            $display("FAIL addr_wrap: got %h/%h expected 00/00", addr2, led_addr2);
        else passes++;
        checks++;
        if (av_address !== 25'h100 || led_addr !== 8'h00)
            $display("FAIL addr_carry: got %h/%h expected 100/00", av_address, led_addr);
        else passes++;
        exp_addr = 25'h100;
        $display("addr: 256 presses -> wide %h narrow %h", av_address, addr2);
    endtask

    task automatic test_write();
        int low = 0;
        int bad = 0;
        sw_data = 16'hA5C3; wait_req = 1'b1; bw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (write_n == 1'b0) begin
                low++;
                if ({wdata, av_address, be_n, cs, busy} !== {32'h0000A5C3, exp_addr, 4'h0, 1'b1, 1'b1}) bad++;
                if (low == 4) wait_req = 1'b0;
            end else if (low > 0) begin
                break;
            end
        end
        checks++;
        if (low != 4) $display("FAIL write_len: got %0d expected 4", low);
        else passes++;
        checks++;
        if (bad != 0) $display("FAIL write_stable: got %0d bad cycles expected 0", bad);
        else passes++;
        checks++;
        if ({busy, cs, be_n} !== {1'b0, 1'b0, 4'hF})
            $display("FAIL write_end: got %b expected 000_1111", {busy, cs, be_n});
        else passes++;
        $display("write: data %h addr %h write_n low %0d cycles", wdata, av_address, low);
        bw = 1'b1; step(8);
    endtask

    task automatic test_read();
        int low = 0;
        rdata = 32'hDEAD5555; rvalid = 1'b1; step(1); rvalid = 1'b0;
        checks++;
        if (led !== 16'h0000) $display("FAIL rvalid_idle: got %h expected 0000", led);
        else passes++;
        wait_req = 1'b0; br = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (read_n == 1'b0) low++;
            else if (low > 0) break;
        end
        checks++;
        if (low != 1 || {busy, cs, be_n} !== {1'b1, 1'b0, 4'hF})
            $display("FAIL read_req: got len %0d bus %b expected len 1 bus 101111", low, {busy, cs, be_n});
        else passes++;
        @(negedge clk);
        rdata = 32'h1234BEEF; rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0; rdata = 32'h0;
        checks++;
        if (led !== 16'hBEEF || busy !== 1'b0)
            $display("FAIL read_data: got led %h busy %b expected beef 0", led, busy);
        else passes++;
        $display("read: led %h busy %b", led, busy);
        br = 1'b1; step(8);
    endtask

    task automatic test_bounce();
        int falls = 0;
        logic prev = 1'b1;
        sw_data = 16'h0F0F; wait_req = 1'b0;
        for (int k = 0; k < 60; k++) begin
            bw = (k < 20) ? (((k / 2) % 2) == 1) : 1'b0;
            @(negedge clk);
            if (prev && !write_n) falls++;
            prev = write_n;
        end
        checks++;
        if (falls != 1) $display("FAIL bounce_count: got %0d writes expected 1", falls);
        else passes++;
        checks++;
        if (wdata !== 32'h00000F0F) $display("FAIL bounce_data: got %h expected 00000f0f", wdata);
        else passes++;
        $display("bounce: %0d write(s) issued", falls);
        bw = 1'b1; step(8);
    endtask

    task automatic test_timeout();
        int busy_cnt = 0;
        wait_req = 1'b0; rvalid = 1'b0; br = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (!read_n) ba = 1'b0;
            if (busy_cnt > 0 && !busy) break;
        end
        checks++;
        if (busy_cnt != 16) $display("FAIL timeout_len: got %0d busy cycles expected 16", busy_cnt);
        else passes++;
        checks++;
        if ({error, read_n, cs, be_n} !== {1'b1, 1'b1, 1'b0, 4'hF})
            $display("FAIL timeout_flag: got %b expected 1101111", {error, read_n, cs, be_n});
        else passes++;
        checks++;
        if (av_address !== exp_addr) $display("FAIL addr_busy_drop: got %h expected %h", av_address, exp_addr);
        else passes++;
        rdata = 32'h0000FFFF; rvalid = 1'b1; step(1); rvalid = 1'b0;
        checks++;
        if (led !== 16'hBEEF) $display("FAIL late_rvalid: got %h expected beef", led);
        else passes++;
        br = 1'b1; ba = 1'b1; step(8);
        sw_data = 16'h1111; bw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!write_n) break;
        end
        checks++;
        if ({write_n, error} !== 2'b00) $display("FAIL error_clear: got %b expected 00", {write_n, error});
        else passes++;
        $display("timeout: busy %0d cycles, error cleared by write=%b", busy_cnt, ~error);
        bw = 1'b1; step(8);
    endtask

    task automatic test_collision_reset();
        int wfalls = 0;
        int rlow = 0;
        logic prev = 1'b1;
        sw_data = 16'h2222; wait_req = 1'b0;
        bw = 1'b0; br = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prev && !write_n) wfalls++;
            if (!read_n) rlow++;
            prev = write_n;
        end
        checks++;
        if (wfalls != 1 || rlow != 0)
            $display("FAIL collision: got writes %0d reads %0d expected 1 0", wfalls, rlow);
        else passes++;
        $display("collision: writes %0d reads %0d", wfalls, rlow);
        bw = 1'b1; br = 1'b1; step(8);
        br = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!read_n) break;
        end
        @(negedge clk);
        checks++;
        if ({busy, read_n} !== 2'b11) $display("FAIL rd_wait_entry: got %b expected 11", {busy, read_n});
        else passes++;
        #3 reset = 1'b0;
        #1;
        checks++;
        if (snap !== SNAP_RESET) $display("FAIL reset_mid: got %h expected %h", snap, SNAP_RESET);
        else passes++;
        @(negedge clk);
        br = 1'b1; step(2);
        reset = 1'b1; step(2);
        rdata = 32'h0000CAFE; rvalid = 1'b1; step(1); rvalid = 1'b0; step(1);
        checks++;
        if (snap !== SNAP_RESET) $display("FAIL reset_no_complete: got %h expected %h", snap, SNAP_RESET);
        else passes++;
        $display("reset mid-read: outputs=%h", snap);
    endtask

    initial begin
        exp_addr = 25'd0;
        test_reset();
        test_addr_wrap();
        test_write();
        test_read();
        test_bounce();
        test_timeout();
        test_collision_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
